// File: rtl/dbp.sv
// Debounce-and-pulse front end for a bouncing push-button.
// Two-flop synchroniser, debounce FSM on both edges, single-cycle enable
// pulses on accepted press plus optional auto-repeat while held.
module dbp #(
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 10,
    parameter int REPEAT_PERIOD = 5
) (
    input  logic dbp_clk,
    input  logic dbp_rst_n,
    input  logic dbp_btn,
    output logic dbp_pulse,
    output logic dbp_level,
    output logic dbp_busy
);

    localparam int MAX_A = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
    localparam int MAX_P = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST   = CW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    logic          r_sync1, r_sync2;
    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_db_cnt, w_db_nx;
    logic [CW-1:0] r_rep_cnt, w_rep_nx;
    logic          r_first, w_first_nx;
    logic          r_pulse, w_pulse_nx;
    logic          r_level, w_level_nx;
    logic          r_busy;
    logic          w_s;
    logic [CW-1:0] w_thr;

    assign w_s   = r_sync2;
    // First repeat after a fresh press waits the long delay, later ones the period.
    assign w_thr = r_first ? DELAY_LAST : PER_LAST;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge dbp_clk or negedge dbp_rst_n) begin
        if (!dbp_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= dbp_btn;
            r_sync2 <= r_sync1;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge dbp_clk or negedge dbp_rst_n) begin
        if (!dbp_rst_n) begin
            r_state   <= IDLE;
            r_db_cnt  <= '0;
            r_rep_cnt <= '0;
            r_first   <= 1'b0;
            r_pulse   <= 1'b0;
            r_level   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_db_cnt  <= w_db_nx;
            r_rep_cnt <= w_rep_nx;
            r_first   <= w_first_nx;
            r_pulse   <= w_pulse_nx;
            r_level   <= w_level_nx;
            r_busy    <= (w_state_nx != IDLE);
        end
    end

    // Next-state and next-output logic; counters clear at their threshold so they never wrap.
    always_comb begin
        w_state_nx = r_state;
        w_db_nx    = r_db_cnt;
        w_rep_nx   = r_rep_cnt;
        w_first_nx = r_first;
        w_pulse_nx = 1'b0;
        w_level_nx = r_level;
        case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_state_nx = PRESS_DB;
                    w_db_nx    = '0;
                end
            end
            PRESS_DB: begin
                if (!w_s) begin
                    w_state_nx = IDLE;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nx = HELD;
                    w_pulse_nx = 1'b1;
                    w_level_nx = 1'b1;
                    w_rep_nx   = '0;
                    w_first_nx = 1'b1;
                end else begin
                    w_db_nx = r_db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_s) begin
                    w_state_nx = RELEASE_DB;
                    w_db_nx    = '0;
                end else if (REPEAT_EN != 0) begin
                    if (r_rep_cnt == w_thr) begin
                        w_pulse_nx = 1'b1;
                        w_rep_nx   = '0;
                        w_first_nx = 1'b0;
                    end else begin
                        w_rep_nx = r_rep_cnt + 1'b1;
                    end
                end
            end
            RELEASE_DB: begin
                // A high sample here is release bounce: back to HELD, repeat count frozen.
                if (w_s) begin
                    w_state_nx = HELD;
                end else if (r_db_cnt == DB_LAST) begin
                    w_state_nx = IDLE;
                    w_level_nx = 1'b0;
                end else begin
                    w_db_nx = r_db_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign dbp_pulse = r_pulse;
    assign dbp_level = r_level;
    assign dbp_busy  = r_busy;

endmodule

// File: tb/tb_dbp.sv
// Scoreboard bench for dbp: stimulus pushes expected pulse edge numbers,
// monitors pop them whenever a pulse appears.
module tb_dbp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn0 = 1'b0, btn1 = 1'b0;
    logic pulse0, level0, busy0;
    logic pulse1, level1, busy1;

    int cyc = 0;
    int t0 = 0;
    int nvec = 0;
    int nerr = 0;
    int q0[$];
    int q1[$];
    logic [3:0] cnt4 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbp u0 (
        .dbp_clk(clk), .dbp_rst_n(rst_n), .dbp_btn(btn0),
        .dbp_pulse(pulse0), .dbp_level(level0), .dbp_busy(busy0)
    );

    dbp #(.REPEAT_EN(0)) u1 (
        .dbp_clk(clk), .dbp_rst_n(rst_n), .dbp_btn(btn1),
        .dbp_pulse(pulse1), .dbp_level(level1), .dbp_busy(busy1)
    );

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Wait until the negedge following absolute edge t0+k.
    task automatic at(input int k);
        while (cyc < t0 + k) @(negedge clk);
    endtask

    // Start a press: the next rising edge is edge 0.
    task automatic start(input bit which);
        @(negedge clk);
        t0 = cyc + 1;
        if (which) btn1 = 1'b1; else btn0 = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, int'(busy0 | busy1), 0);
        chk({name, "_q0_empty"}, q0.size(), 0);
        chk({name, "_q1_empty"}, q1.size(), 0);
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
    endtask

    // Monitor for u0: every pulse must match the next expected edge.
    initial begin
        bit prev;
        int e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && pulse0) begin
                cnt4 = cnt4 + 4'd1;
                if (q0.size() == 0) chk("u0_unexpected_pulse", cyc, -1);
                else begin
                    e = q0.pop_front();
                    chk("u0_pulse_edge", cyc, e);
                end
                if (prev) chk("u0_double_pulse", 1, 0);
            end
            prev = pulse0;
        end
    end

    // Monitor for u1 (no auto-repeat).
    initial begin
        bit prev;
        int e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && pulse1) begin
                if (q1.size() == 0) chk("u1_unexpected_pulse", cyc, -1);
                else begin
                    e = q1.pop_front();
                    chk("u1_pulse_edge", cyc, e);
                end
                if (prev) chk("u1_double_pulse", 1, 0);
            end
            prev = pulse1;
        end
    end

    initial begin
        int c;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pulse0", pulse0, 0);
        chk("rst_level0", level0, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_level1", level1, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: clean press held 8 cycles
        start(0);
        q0.push_back(t0 + 6);
        at(5);  chk("t1_level_pre", level0, 0);
        at(6);  chk("t1_level_set", level0, 1);
        at(7);  btn0 = 1'b0;
        at(13); chk("t1_level_hold", level0, 1);
        at(14); chk("t1_level_fall", level0, 0);
        wait_idle("t1");

        // Glitch of one sample: rejected
        start(0);
        at(0);  btn0 = 1'b0;
        at(8);  chk("g1_level", level0, 0);
        wait_idle("g1");

        // Glitch of four samples (DB_CYCLES): still rejected
        start(0);
        at(3);  btn0 = 1'b0;
        at(6);  chk("g4_level6", level0, 0);
        at(7);  chk("g4_level7", level0, 0);
        wait_idle("g4");

        // 2: press bounce 1,1,0 then held
        start(0);
        q0.push_back(t0 + 9);
        at(1);  btn0 = 1'b0;
        at(2);  btn0 = 1'b1;
        at(8);  chk("t2_level_pre", level0, 0);
        at(9);  chk("t2_level_set", level0, 1);
        at(10); btn0 = 1'b0;
        wait_idle("t2");

        // 3: auto-repeat
        cnt4 = '0;
        start(0);
        q0.push_back(t0 + 6);
        q0.push_back(t0 + 16);
        q0.push_back(t0 + 21);
        q0.push_back(t0 + 26);
        at(27); btn0 = 1'b0;
        at(33); chk("t3_level_hold", level0, 1);
        at(34); chk("t3_level_fall", level0, 0);
        wait_idle("t3");
        chk("t3_counter", cnt4, 4);

        // 4: release bounce
        start(0);
        q0.push_back(t0 + 6);
        at(7);  btn0 = 1'b0;
        at(9);  btn0 = 1'b1;
        at(12); chk("t4_level_bounce", level0, 1);
        at(13); btn0 = 1'b0;
        at(15); chk("t4_level_b2", level0, 1);
        at(19); chk("t4_level_hold", level0, 1);
        at(20); chk("t4_level_fall", level0, 0);
        wait_idle("t4");

        // 5: reset during PRESS_DB, off-edge
        start(0);
        at(3);  chk("t5_busy_pre", busy0, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_pulse", pulse0, 0);
        chk("t5_rst_level", level0, 0);
        chk("t5_rst_busy", busy0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        t0 = c + 1;
        q0.push_back(t0 + 6);
        at(5);  chk("t5_level_pre", level0, 0);
        at(6);  chk("t5_level_set", level0, 1);
        at(7);  btn0 = 1'b0;
        wait_idle("t5");

        // 6: no auto-repeat, hold 50 cycles
        start(1);
        q1.push_back(t0 + 6);
        at(1);  chk("t6_busy_early", busy1, 0);
        at(3);  chk("t6_busy_on", busy1, 1);
        at(49); btn1 = 1'b0;
        chk("t6_level_held", level1, 1);
        at(55); chk("t6_busy_hold", busy1, 1);
        at(56); chk("t6_busy_off", busy1, 0);
        chk("t6_level_fall", level1, 0);
        wait_idle("t6");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: cycle %0d reached limit", cyc);
        $fatal(1);
    end

endmodule
